// File: rtl/riscv_v_pkg.sv
// Shared RISC-V vector types for the execute path.
// Contents: element-width and multiply-op enums, ELEN and lane mask width.
package riscv_v_pkg;

  localparam int unsigned ELEN        = 64;
  localparam int unsigned LANE_MASK_W = ELEN / 8;

  typedef enum logic [1:0] {
    E8  = 2'd0,
    E16 = 2'd1,
    E32 = 2'd2,
    E64 = 2'd3
  } sew_t;

  typedef enum logic [1:0] {
    VMUL    = 2'd0,
    VMULH   = 2'd1,
    VMULHU  = 2'd2,
    VMULHSU = 2'd3
  } mul_op_t;

endpackage

// File: rtl/vector_multiply_lane.sv
// One 64-bit multiply lane (combinational), all SEW splits and mul ops.
// Ports:
//   mul_op_i  - multiply flavour
//   sew_i     - element width
//   vm_i      - 1 = unmasked
//   mask_i    - per-element enables for this lane (low 64/SEW bits used)
//   vs2_i     - multiplicand slice
//   vs1_i     - multiplier slice
//   vd_old_i  - prior destination slice, kept for inactive elements
//   vd_o      - result slice
module vector_multiply_lane
  import riscv_v_pkg::*;
(
  input  mul_op_t                  mul_op_i,
  input  sew_t                     sew_i,
  input  logic                     vm_i,
  input  logic [LANE_MASK_W-1:0]   mask_i,
  input  logic [ELEN-1:0]          vs2_i,
  input  logic [ELEN-1:0]          vs1_i,
  input  logic [ELEN-1:0]          vd_old_i,
  output logic [ELEN-1:0]          vd_o
);

  // Multiply one element of width w (operands zero-extended to 64 bits).
  // Signed operands are sign-filled up to 65 bits so one signed multiplier
  // serves every signedness combination.
  function automatic logic [ELEN-1:0] mul_elem(
    input mul_op_t         op,
    input logic [ELEN-1:0] a,
    input logic [ELEN-1:0] b,
    input logic [6:0]      w
  );
    logic            a_sgn;
    logic            b_sgn;
    logic [ELEN:0]   hi_fill;
    logic [ELEN:0]   ax;
    logic [ELEN:0]   bx;
    logic [2*ELEN-1:0] p;
    a_sgn   = (op == VMULH) || (op == VMULHSU);
    b_sgn   = (op == VMULH);
    hi_fill = ~(((ELEN+1)'(1) << w) - (ELEN+1)'(1));
    ax      = {1'b0, a};
    bx      = {1'b0, b};
    if (a_sgn && a[6'(w - 7'd1)]) ax = ax | hi_fill;
    if (b_sgn && b[6'(w - 7'd1)]) bx = bx | hi_fill;
    p = (2*ELEN)'($signed(ax)) * (2*ELEN)'($signed(bx));
    return (op == VMUL) ? p[ELEN-1:0] : ELEN'(p >> w);
  endfunction

  logic [ELEN-1:0] r;

  // Per-SEW element loop; inactive elements keep vd_old.
  always_comb begin
    vd_o = vd_old_i;
    r    = '0;
    case (sew_i)
      E8: for (int j = 0; j < 8; j++) begin
        r = mul_elem(mul_op_i, ELEN'(vs2_i[8*j +: 8]), ELEN'(vs1_i[8*j +: 8]), 7'd8);
        if (vm_i || mask_i[j]) vd_o[8*j +: 8] = r[7:0];
      end
      E16: for (int j = 0; j < 4; j++) begin
        r = mul_elem(mul_op_i, ELEN'(vs2_i[16*j +: 16]), ELEN'(vs1_i[16*j +: 16]), 7'd16);
        if (vm_i || mask_i[j]) vd_o[16*j +: 16] = r[15:0];
      end
      E32: for (int j = 0; j < 2; j++) begin
        r = mul_elem(mul_op_i, ELEN'(vs2_i[32*j +: 32]), ELEN'(vs1_i[32*j +: 32]), 7'd32);
        if (vm_i || mask_i[j]) vd_o[32*j +: 32] = r[31:0];
      end
      E64: begin
        r = mul_elem(mul_op_i, vs2_i, vs1_i, 7'd64);
        if (vm_i || mask_i[0]) vd_o = r;
      end
    endcase
  end

endmodule

// File: rtl/vector_multiply_pipeline.sv
// Handshaked element-wise vector multiply pipeline (vmul/vmulh/vmulhu/vmulhsu).
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   - operand handshake
//   mul_op, sew, vm       - operation, element width, unmasked flag
//   v0_mask               - element enables when vm=0
//   vs2, vs1, vd_old      - operands and prior destination
//   out_valid / out_ready - result handshake
//   vd                    - result vector
//   busy                  - any stage holds a valid entry
module vector_multiply_pipeline
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN        = 128,
  parameter int unsigned PIPE_STAGES = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mul_op,
  input  logic [1:0]        sew,
  input  logic              vm,
  input  logic [VLEN/8-1:0] v0_mask,
  input  logic [VLEN-1:0]   vs2,
  input  logic [VLEN-1:0]   vs1,
  input  logic [VLEN-1:0]   vd_old,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VLEN-1:0]   vd,
  output logic              busy
);

  localparam int unsigned MASK_W = VLEN / 8;
  localparam int unsigned LANES  = VLEN / ELEN;

  logic              advance;
  logic              s1_valid_q;
  mul_op_t           s1_op_q;
  sew_t              s1_sew_q;
  logic              s1_vm_q;
  logic [MASK_W-1:0] s1_mask_q;
  logic [VLEN-1:0]   s1_vs2_q;
  logic [VLEN-1:0]   s1_vs1_q;
  logic [VLEN-1:0]   s1_vd_old_q;
  logic [VLEN-1:0]   res_d;

  // Whole pipe moves together; a full pipe with a blocked consumer freezes.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: operand capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= VMUL;
      s1_sew_q    <= E8;
      s1_vm_q     <= 1'b0;
      s1_mask_q   <= '0;
      s1_vs2_q    <= '0;
      s1_vs1_q    <= '0;
      s1_vd_old_q <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_op_q     <= mul_op_t'(mul_op);
        s1_sew_q    <= sew_t'(sew);
        s1_vm_q     <= vm;
        s1_mask_q   <= v0_mask;
        s1_vs2_q    <= vs2;
        s1_vs1_q    <= vs1;
        s1_vd_old_q <= vd_old;
      end
    end
  end

  // Lanes; each picks its slice of v0 according to how many elements it holds.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [LANE_MASK_W-1:0] lane_mask;

    always_comb begin
      lane_mask = '0;
      case (s1_sew_q)
        E8:  lane_mask = s1_mask_q[8*l +: 8];
        E16: lane_mask = {4'b0, s1_mask_q[4*l +: 4]};
        E32: lane_mask = {6'b0, s1_mask_q[2*l +: 2]};
        E64: lane_mask = {7'b0, s1_mask_q[l]};
      endcase
    end

    vector_multiply_lane u_lane (
      .mul_op_i (s1_op_q),
      .sew_i    (s1_sew_q),
      .vm_i     (s1_vm_q),
      .mask_i   (lane_mask),
      .vs2_i    (s1_vs2_q[ELEN*l +: ELEN]),
      .vs1_i    (s1_vs1_q[ELEN*l +: ELEN]),
      .vd_old_i (s1_vd_old_q[ELEN*l +: ELEN]),
      .vd_o     (res_d[ELEN*l +: ELEN])
    );
  end

  // Result stages 2..PIPE_STAGES.
  if (PIPE_STAGES == 1) begin : g_comb_out
    assign vd        = res_d;
    assign out_valid = s1_valid_q;
    assign busy      = s1_valid_q;
  end else begin : g_reg_out
    localparam int unsigned RS = PIPE_STAGES - 1;
    logic [VLEN-1:0] res_q [RS];
    logic [RS-1:0]   rval_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int k = 0; k < RS; k++) res_q[k] <= '0;
        rval_q <= '0;
      end else if (advance) begin
        res_q[0]  <= res_d;
        rval_q[0] <= s1_valid_q;
        for (int k = 1; k < RS; k++) begin
          res_q[k]  <= res_q[k-1];
          rval_q[k] <= rval_q[k-1];
        end
      end
    end

    assign vd        = res_q[RS-1];
    assign out_valid = rval_q[RS-1];
    assign busy      = s1_valid_q | (|rval_q);
  end

endmodule

// File: tb/tb_vector_multiply_pipeline.sv
// Self-checking bench for vector_multiply_pipeline (VLEN=128, 3 stages).
module tb_vector_multiply_pipeline;

  localparam int VLEN = 128;
  localparam int PIPE = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mul_op;
  logic [1:0]        sew;
  logic              vm;
  logic [VLEN/8-1:0] v0_mask;
  logic [VLEN-1:0]   vs2;
  logic [VLEN-1:0]   vs1;
  logic [VLEN-1:0]   vd_old;
  logic              out_valid;
  logic              out_ready;
  logic [VLEN-1:0]   vd;
  logic              busy;

  always #5 clock = ~clock;

  vector_multiply_pipeline #(.VLEN(VLEN), .PIPE_STAGES(PIPE)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mul_op    (mul_op),
    .sew       (sew),
    .vm        (vm),
    .v0_mask   (v0_mask),
    .vs2       (vs2),
    .vs1       (vs1),
    .vd_old    (vd_old),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .vd        (vd),
    .busy      (busy)
  );

  int              n_cmp  = 0;
  int              n_fail = 0;
  int              n_out  = 0;
  logic [VLEN-1:0] exp_q[$];
  logic            use_const = 1'b0;
  logic [VLEN-1:0] const_exp = '0;

  // Reference: each element as an integer, sign-adjusted by subtracting 2^SEW.
  function automatic logic [VLEN-1:0] model(input logic [1:0] op, input logic [1:0] sw,
                                            input logic m_vm, input logic [VLEN/8-1:0] m,
                                            input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                            input logic [VLEN-1:0] old);
    int w;
    int n;
    logic [VLEN-1:0] lm, ea, eb, r, res;
    logic signed [VLEN-1:0] sa, sb, p;
    w   = 8 << sw;
    n   = VLEN / w;
    lm  = (128'd1 << w) - 128'd1;
    res = old;
    for (int i = 0; i < n; i++) begin
      ea = (a >> (i * w)) & lm;
      eb = (b >> (i * w)) & lm;
      sa = ea;
      sb = eb;
      if ((op == 2'd1 || op == 2'd3) && ea[w-1]) sa = ea - (128'd1 << w);
      if (op == 2'd1 && eb[w-1]) sb = eb - (128'd1 << w);
      p = sa * sb;
      r = (op == 2'd0) ? (p & lm) : ((p >> w) & lm);
      if (m_vm || m[i]) res = (res & ~(lm << (i * w))) | (r << (i * w));
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, score outputs, queue accepted inputs.
  task automatic tick(output logic acc, output logic ird);
    #2;
    acc = 1'b0;
    ird = in_ready;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 128'(out_valid), 128'(0));
        else check("vd", vd, exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        if (use_const) exp_q.push_back(const_exp);
        else exp_q.push_back(model(mul_op, sew, vm, v0_mask, vs2, vs1, vd_old));
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_rand();
    mul_op  = 2'($urandom_range(0, 3));
    sew     = 2'($urandom_range(0, 3));
    vm      = 1'($urandom_range(0, 1));
    v0_mask = 16'($urandom);
    vs2     = {$urandom, $urandom, $urandom, $urandom};
    vs1     = {$urandom, $urandom, $urandom, $urandom};
    vd_old  = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) vs2 = '1;
    if ($urandom_range(0, 3) == 0) vs1 = {8{16'h8000}};
  endtask

  // Single directed transfer into an empty pipe; checks latency and result.
  task automatic directed(input string tag, input logic [1:0] op, input logic [1:0] sw,
                          input logic dvm, input logic [15:0] m, input logic [VLEN-1:0] a,
                          input logic [VLEN-1:0] b, input logic [VLEN-1:0] old,
                          input logic [VLEN-1:0] exp);
    logic acc, ird;
    int n;
    mul_op = op; sew = sw; vm = dvm; v0_mask = m; vs2 = a; vs1 = b; vd_old = old;
    in_valid = 1'b1; out_ready = 1'b1; use_const = 1'b1; const_exp = exp;
    tick(acc, ird);
    in_valid = 1'b0; use_const = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick(acc, ird);
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(PIPE - 1));
    tick(acc, ird);
  endtask

  initial begin
    logic acc, ird, saw_low;
    int t, accepted, out_start;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mul_op = '0; sew = '0; vm = 1'b1; v0_mask = '0; vs2 = '0; vs1 = '0; vd_old = '0;
    tick(acc, ird);
    tick(acc, ird);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_vd", vd, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    reset = 1'b0;
    tick(acc, ird);
    check("post_rst_out_valid", 128'(out_valid), 128'(0));
    check("post_rst_vd", vd, 128'(0));
    check("post_rst_busy", 128'(busy), 128'(0));
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Directed arithmetic corner cases.
    directed("e8_vmul",    2'd0, 2'd0, 1'b1, 16'h0, 128'hFF, 128'h02, '0, 128'hFE);
    directed("e8_vmulh",   2'd1, 2'd0, 1'b1, 16'h0, 128'hFF, 128'h02, '0, 128'hFF);
    directed("e8_vmulhu",  2'd2, 2'd0, 1'b1, 16'h0, 128'hFF, 128'h02, '0, 128'h01);
    directed("e8_vmulhsu", 2'd3, 2'd0, 1'b1, 16'h0, 128'hFF, 128'h02, '0, 128'hFF);
    directed("e32_vmulh",  2'd1, 2'd2, 1'b1, 16'h0, {4{32'h80000000}}, {4{32'h80000000}},
             '1, {4{32'h40000000}});
    directed("e32_vmulhu", 2'd2, 2'd2, 1'b1, 16'h0, {4{32'h80000000}}, {4{32'h80000000}},
             '1, {4{32'h40000000}});
    directed("e32_vmul",   2'd0, 2'd2, 1'b1, 16'h0, {4{32'h80000000}}, {4{32'h80000000}},
             '1, '0);
    directed("e64_vmulhu", 2'd2, 2'd3, 1'b1, 16'h0, '1, '1, '0, {2{64'hFFFFFFFFFFFFFFFE}});
    directed("e64_vmul",   2'd0, 2'd3, 1'b1, 16'h0, '1, '1, '0, {2{64'h0000000000000001}});
    directed("e16_masked", 2'd0, 2'd1, 1'b0, 16'h5555, {8{16'h0003}}, {8{16'h0003}},
             {8{16'hAAAA}}, {4{16'hAAAA, 16'h0009}});

    // Eight back-to-back transfers with a 4-cycle consumer stall mid-stream.
    out_start = n_out; accepted = 0; t = 0; saw_low = 1'b0;
    set_rand();
    in_valid = 1'b1;
    while (accepted < 8 && t < 100) begin
      out_ready = !(t >= 3 && t < 7);
      tick(acc, ird);
      if (!ird) saw_low = 1'b1;
      if (acc) begin
        accepted++;
        set_rand();
      end
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() > 0 && t < 200) begin
      tick(acc, ird);
      t++;
    end
    check("stall_in_ready_drop", 128'(saw_low), 128'(1));
    check("stall_out_count", 128'(n_out - out_start), 128'(8));

    // Random traffic with random producer and consumer gaps.
    out_start = n_out; accepted = 0; t = 0;
    set_rand();
    in_valid = 1'($urandom_range(0, 3) != 0);
    while (accepted < 40 && t < 1000) begin
      out_ready = 1'($urandom_range(0, 9) < 7);
      tick(acc, ird);
      if (acc) accepted++;
      if (!in_valid || acc) begin
        set_rand();
        in_valid = 1'($urandom_range(0, 3) != 0);
      end
      t++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() > 0 && t < 1200) begin
      tick(acc, ird);
      t++;
    end
    check("rand_out_count", 128'(n_out - out_start), 128'(40));

    // Reset with two entries in flight.
    out_ready = 1'b1;
    set_rand();
    in_valid = 1'b1;
    tick(acc, ird);
    set_rand();
    tick(acc, ird);
    in_valid = 1'b0;
    check("inflight_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    tick(acc, ird);
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_vd", vd, 128'(0));
    exp_q.delete();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(acc, ird);
      check("no_stale_out_valid", 128'(out_valid), 128'(0));
    end

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
